// File: rtl/rect_fill_streamer_pkg.sv
// Shared ILI9341 display types: RGB565 colour, named colours and panel geometry.
package rect_fill_streamer_pkg;

  typedef logic [15:0] ILI9341_color_t;

  localparam ILI9341_color_t BLACK = 16'h0000;
  localparam ILI9341_color_t RED   = 16'hF800;
  localparam ILI9341_color_t GREEN = 16'h07E0;
  localparam ILI9341_color_t BLUE  = 16'h001F;

  localparam int ILI9341_WIDTH   = 240;
  localparam int ILI9341_HEIGHT  = 320;
  localparam int ILI9341_COORD_W = 9;

endpackage

// File: rtl/rect_fill_streamer_raster.sv
// Raster-order x/y counter: load a window, step x fastest, flag the final position.
module raster_counter #(
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [COORD_W-1:0] end_x,
  input  logic [COORD_W-1:0] end_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] x_first;
  logic [COORD_W-1:0] x_end;
  logic [COORD_W-1:0] y_end;

  assign last = (x == x_end) && (y == y_end);

  // Advancing from the final position is suppressed so x/y never leave the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      x_first <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else if (load) begin
      x       <= start_x;
      y       <= start_y;
      x_first <= start_x;
      x_end   <= end_x;
      y_end   <= end_y;
    end else if (advance && !last) begin
      if (x == x_end) begin
        x <= x_first;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_fill_streamer.sv
// Streams a clipped, single-colour rectangle one pixel per valid/ready beat in raster order.
module rect_fill_streamer
  import rect_fill_streamer_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = ILI9341_WIDTH,
  parameter int DISPLAY_HEIGHT = ILI9341_HEIGHT,
  parameter int COORD_W        = ILI9341_COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  input  ILI9341_color_t     color,
  output logic               busy,
  output logic               done,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output ILI9341_color_t     pixel_color
);

  // Handshake: a beat transfers on a rising edge where pixel_valid && pixel_ready;
  // while pixel_valid is high and pixel_ready low, every pixel_* output holds.

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  state_t state_q, state_d;

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0] WIDTH_EXT  = CW1'(DISPLAY_WIDTH);
  localparam logic [COORD_W:0] HEIGHT_EXT = CW1'(DISPLAY_HEIGHT);

  logic [COORD_W:0] x0_e, y0_e, w_e, h_e, room_x, room_y, ew, eh, end_x, end_y;
  logic             empty, load, advance, last;

  // Extents are clipped with one guard bit so x0+w can never wrap.
  always_comb begin
    x0_e   = {1'b0, x0};
    y0_e   = {1'b0, y0};
    w_e    = {1'b0, w};
    h_e    = {1'b0, h};
    room_x = WIDTH_EXT - x0_e;
    room_y = HEIGHT_EXT - y0_e;
    ew     = (x0_e >= WIDTH_EXT)  ? '0 : ((w_e < room_x) ? w_e : room_x);
    eh     = (y0_e >= HEIGHT_EXT) ? '0 : ((h_e < room_y) ? h_e : room_y);
    end_x  = x0_e + ew - CW1'(1);
    end_y  = y0_e + eh - CW1'(1);
    empty  = (ew == '0) || (eh == '0);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = !empty;
          state_d = empty ? FINISH : STREAM;
        end
      end
      STREAM: begin
        if (pixel_ready) begin
          advance = 1'b1;
          if (last) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         pixel_color <= BLACK;
    else if (state_q == IDLE && start) pixel_color <= color;
  end

  raster_counter #(.COORD_W(COORD_W)) u_raster (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .start_x (x0),
    .start_y (y0),
    .end_x   (COORD_W'(end_x)),
    .end_y   (COORD_W'(end_y)),
    .x       (pixel_x),
    .y       (pixel_y),
    .last    (last)
  );

  assign busy        = (state_q == STREAM);
  assign pixel_valid = (state_q == STREAM);
  assign done        = (state_q == FINISH);

endmodule

// File: tb/tb_rect_fill_streamer.sv
// Bench for rect_fill_streamer: directed scenarios plus randomized edge rectangles vs a raster model.
module tb_rect_fill_streamer;

  localparam int CW = 9;
  localparam int PW = 2 * CW + 16;

  logic          clk = 1'b0;
  logic          rst, start, pixel_ready;
  logic [CW-1:0] x0, y0, w, h;
  logic [15:0]   color;
  logic          busy, done, pixel_valid;
  logic [CW-1:0] pixel_x, pixel_y;
  logic [15:0]   pixel_color;

  rect_fill_streamer dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
    .color(color), .busy(busy), .done(done), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_color(pixel_color)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt, done_cycle, first_valid, stall_err, busy_seen;

  // Reference: every on-panel pixel of the requested rectangle, row by row.
  function automatic void build_expected(int bx, int by, int bw, int bh, logic [15:0] c);
    exp_q.delete();
    for (int yy = by; yy < by + bh; yy++)
      for (int xx = bx; xx < bx + bw; xx++)
        if (xx < 240 && yy < 320) exp_q.push_back({CW'(xx), CW'(yy), c});
  endfunction

  task automatic issue(input int bx, input int by, input int bw, input int bh, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1;
    x0 = CW'(bx); y0 = CW'(by); w = CW'(bw); h = CW'(bh); color = c;
  endtask

  // Drives pixel_ready per mode (0 always, 1 random, 2 pattern 1,0,0) and records beats.
  task automatic collect(input int mode, input int extra_start, input int max_cycles);
    bit            stalled = 1'b0;
    logic [PW-1:0] held = '0;
    logic          r;
    obs_q.delete();
    done_cnt = 0; done_cycle = -1; first_valid = -1; stall_err = 0; busy_seen = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        x0 = CW'($urandom); y0 = CW'($urandom); w = CW'($urandom); h = CW'($urandom);
        color = 16'($urandom);
      end
      if (c == extra_start) begin
        start = 1'b1; color = 16'h001F; x0 = '0; y0 = '0; w = 9'd5; h = 9'd5;
      end
      if (c == extra_start + 1) start = 1'b0;
      if (pixel_valid) begin
        if (first_valid < 0) first_valid = c;
        if (stalled && {pixel_x, pixel_y, pixel_color} !== held) stall_err++;
      end
      if (busy) busy_seen++;
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = ((c - 1) % 3 == 0);
      endcase
      pixel_ready = r;
      stalled = pixel_valid && !r;
      held = {pixel_x, pixel_y, pixel_color};
      if (pixel_valid && r) obs_q.push_back({pixel_x, pixel_y, pixel_color});
      if (done_cycle >= 0 && c >= done_cycle + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
    #3;
    n_checks++;
    if ({busy, done, pixel_valid, pixel_x, pixel_y, pixel_color} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b valid=%0b x=%0d y=%0d c=%h, want all zero",
               busy, done, pixel_valid, pixel_x, pixel_y, pixel_color);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    build_expected(10, 20, 2, 2, 16'hF800);
    issue(10, 20, 2, 2, 16'hF800);
    collect(0, -10, 40);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_beat%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (first_valid != 1 || done_cycle != 5 || done_cnt != 1 || busy_seen != 4) begin
      n_fail++;
      $display("FAIL basic_timing: got first=%0d done_at=%0d dones=%0d busy=%0d, want 1 5 1 4",
               first_valid, done_cycle, done_cnt, busy_seen);
    end
  endtask

  task automatic test_backpressure;
    build_expected(10, 20, 2, 2, 16'hF800);
    issue(10, 20, 2, 2, 16'hF800);
    collect(2, -10, 60);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (stall_err != 0 || done_cnt != 1 || done_cycle != 11) begin
      n_fail++;
      $display("FAIL bp_hold: got stall_err=%0d dones=%0d done_at=%0d, want 0 1 11",
               stall_err, done_cnt, done_cycle);
    end
  endtask

  task automatic test_clipping;
    build_expected(238, 318, 5, 5, 16'h07E0);
    issue(238, 318, 5, 5, 16'h07E0);
    collect(0, -10, 60);
    n_checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      n_fail++; $display("FAIL clip_count: got %0d beats, want 4", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL clip_beat%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_cycle != 5) begin
      n_fail++; $display("FAIL clip_done: got dones=%0d done_at=%0d, want 1 5", done_cnt, done_cycle);
    end
  endtask

  task automatic test_empty;
    int cases[2][4] = '{'{240, 5, 3, 3}, '{7, 9, 0, 4}};
    for (int k = 0; k < 2; k++) begin
      issue(cases[k][0], cases[k][1], cases[k][2], cases[k][3], 16'hFFFF);
      collect(0, -10, 20);
      n_checks++;
      if (obs_q.size() != 0 || first_valid != -1 || busy_seen != 0 || done_cycle != 1 || done_cnt != 1) begin
        n_fail++;
        $display("FAIL empty%0d: got beats=%0d first=%0d busy=%0d done_at=%0d dones=%0d, want 0 -1 0 1 1",
                 k, obs_q.size(), first_valid, busy_seen, done_cycle, done_cnt);
      end
    end
  endtask

  task automatic test_ignored_start;
    build_expected(5, 5, 3, 1, 16'h07E0);
    issue(5, 5, 3, 1, 16'h07E0);
    collect(0, 2, 40);
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL ign_count: got %0d beats, want 3", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ign_beat%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL ign_done: got %0d done pulses, want 1", done_cnt);
    end
  endtask

  task automatic test_async_reset;
    int dones = 0;
    issue(0, 0, 4, 4, 16'h07E0);
    @(negedge clk);
    start = 1'b0; pixel_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (pixel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_drop: got valid=%0b busy=%0b done=%0b, want 0 0 0", pixel_valid, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || pixel_valid) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL async_quiet: got %0d active cycles after reset, want 0", dones);
    end
    build_expected(3, 4, 2, 1, 16'h001F);
    issue(3, 4, 2, 1, 16'h001F);
    collect(0, -10, 30);
    n_checks++;
    if (obs_q != exp_q || done_cnt != 1) begin
      n_fail++; $display("FAIL async_restart: got %0d beats dones=%0d, want %0d beats 1 done",
                         obs_q.size(), done_cnt, exp_q.size());
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      int bx = $urandom_range(225, 245);
      int by = $urandom_range(305, 325);
      int bw = $urandom_range(0, 12);
      int bh = $urandom_range(0, 6);
      logic [15:0] c = 16'($urandom);
      build_expected(bx, by, bw, bh, c);
      issue(bx, by, bw, bh, c);
      collect(1, -10, 500);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d beats, want %0d", t, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_beat%0d: got %h, want %h", t, i, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (done_cnt != 1 || stall_err != 0) begin
        n_fail++; $display("FAIL rand%0d_done: got dones=%0d stall_err=%0d, want 1 0", t, done_cnt, stall_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_clipping();
    test_empty();
    test_ignored_start();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
